// File: rtl/instr_sequencer.sv
// Multi-cycle fetch / operand / store / execute control FSM for the accumulator CPU.
// Optional macro INSTR_CNT_EN adds a 32-bit retired-instruction counter output.
module instr_sequencer #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned INSTR_W = 14
) (
   input  logic               clk,
   input  logic               rst,
   output logic               mem_req,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ack,
   output logic [5:0]         ir_op,
   output logic [ADDR_W-1:0]  ir_c,
   output logic [DATA_W-1:0]  di,
   input  logic [DATA_W-1:0]  acc_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic               acc_update,
   input  logic               br_taken,
   output logic               acc_we,
   output logic               pc_inc,
   output logic               pc_load,
   output logic               halted
`ifdef INSTR_CNT_EN
   ,
   output logic [31:0]        retired
`endif
);

   localparam int unsigned OP_W = 6;
   localparam logic [OP_W-1:0] OP_STORE = 6'b101000;
   localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_OPRD,
      S_STORE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t state;
   state_t state_nx;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (mem_ack) state_nx = S_DECODE;
         S_DECODE: begin
            if (!ir_op[OP_W-1])       state_nx = ir_op[0] ? S_EXEC : S_OPRD;
            else if (ir_op == OP_STORE) state_nx = S_STORE;
            else if (ir_op == OP_HALT)  state_nx = S_HALT;
            else                        state_nx = S_EXEC;
         end
         S_OPRD:   if (mem_ack) state_nx = S_EXEC;
         S_STORE:  if (mem_ack) state_nx = S_EXEC;
         S_EXEC:   state_nx = S_FETCH;
         S_HALT:   state_nx = S_HALT;
         default:  state_nx = S_FETCH;
      endcase
   end

   // strobes decoded from the state register; held at idle while rst is asserted
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_in;
      acc_we   = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      halted   = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: mem_req = 1'b1;
            S_OPRD: begin
               mem_req  = 1'b1;
               mem_addr = ir_c;
            end
            S_STORE: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               mem_addr = ir_c;
            end
            S_EXEC: begin
               acc_we  = acc_update;
               pc_load = br_taken;
               pc_inc  = ~br_taken;
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign mem_wdata = acc_in;

   // instruction register and operand latch
   always_ff @(posedge clk) begin
      if (rst) begin
         ir_op <= '1;
         ir_c  <= '0;
         di    <= '0;
      end else begin
         case (state)
            S_FETCH: if (mem_ack) begin
               ir_op <= mem_rdata[INSTR_W-1 -: OP_W];
               ir_c  <= mem_rdata[ADDR_W-1:0];
            end
            S_DECODE: if (!ir_op[OP_W-1] && ir_op[0]) di <= DATA_W'(ir_c);
            S_OPRD:   if (mem_ack) di <= mem_rdata[DATA_W-1:0];
            default: ;
         endcase
      end
   end

`ifdef INSTR_CNT_EN
   // one count per executed instruction; wraps naturally
   always_ff @(posedge clk) begin
      if (rst)                  retired <= '0;
      else if (state == S_EXEC) retired <= retired + 32'd1;
   end
`endif

endmodule
